// File: rtl/up_sync_fifo_gen.sv
// up_sync_fifo_gen: single-clock FIFO of 2**ADDR_WIDTH words, DATA_WIDTH bits each.
// Offers show-ahead or normal read mode, programmable almost-full/almost-empty
// thresholds, sticky overflow/underflow flags, a synchronous clear and an
// occupancy count that reaches full depth without wrapping.
//
// Ports:
//   clk, reset       rising-edge clock, asynchronous active-high reset
//   sclr             synchronous clear (pointers, count, sticky flags)
//   write_en/data    push request and word
//   read_en          pop request
//   read_data/valid  output word and its qualifier (mode dependent)
//   fifo_is_empty/full, almost_empty/full, words_used   registered status
//   overflow/underflow                                 sticky error flags
module up_sync_fifo_gen #(
    parameter int DATA_WIDTH         = 32,
    parameter int ADDR_WIDTH         = 7,
    parameter bit SHOWAHEAD          = 1'b1,
    parameter int ALMOST_FULL_LEVEL  = 120,
    parameter int ALMOST_EMPTY_LEVEL = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  sclr,
    input  logic                  write_en,
    input  logic [DATA_WIDTH-1:0] write_data,
    input  logic                  read_en,
    output logic [DATA_WIDTH-1:0] read_data,
    output logic                  read_valid,
    output logic                  fifo_is_empty,
    output logic                  fifo_is_full,
    output logic                  almost_empty,
    output logic                  almost_full,
    output logic [ADDR_WIDTH:0]   words_used,
    output logic                  overflow,
    output logic                  underflow
);
    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] FULL_CNT = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] AF_LVL   = (ADDR_WIDTH+1)'(ALMOST_FULL_LEVEL);
    localparam logic [ADDR_WIDTH:0] AE_LVL   = (ADDR_WIDTH+1)'(ALMOST_EMPTY_LEVEL);
    localparam logic AF_RST = (ALMOST_FULL_LEVEL == 0);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr;
    logic [ADDR_WIDTH:0]   count, count_nxt;
    logic                  push, pop;

    // A push into a full FIFO is still taken when the head is leaving the same cycle.
    assign pop        = read_en & ~fifo_is_empty;
    assign push       = write_en & (~fifo_is_full | pop);
    assign words_used = count;

    always_comb begin
        count_nxt = count;
        case ({push, pop})
            2'b10:   count_nxt = count + 1'b1;
            2'b01:   count_nxt = count - 1'b1;
            default: count_nxt = count;
        endcase
    end

    // Status flags are registered from the next count so they always agree with words_used.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count         <= '0;
            fifo_is_empty <= 1'b1;
            fifo_is_full  <= 1'b0;
            almost_empty  <= 1'b1;
            almost_full   <= AF_RST;
            overflow      <= 1'b0;
            underflow     <= 1'b0;
        end else if (sclr) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count         <= '0;
            fifo_is_empty <= 1'b1;
            fifo_is_full  <= 1'b0;
            almost_empty  <= 1'b1;
            almost_full   <= AF_RST;
            overflow      <= 1'b0;
            underflow     <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count         <= count_nxt;
            fifo_is_empty <= (count_nxt == '0);
            fifo_is_full  <= (count_nxt == FULL_CNT);
            almost_empty  <= (count_nxt <= AE_LVL);
            almost_full   <= (count_nxt >= AF_LVL);
            if (write_en & ~push) overflow  <= 1'b1;
            if (read_en & ~pop)   underflow <= 1'b1;
        end
    end

    // Storage is never cleared; only accepted pushes outside reset/clear write it.
    always_ff @(posedge clk) begin
        if (!reset && !sclr && push) mem[wr_ptr] <= write_data;
    end

    generate
        if (SHOWAHEAD) begin : g_showahead
            // Head word shown combinationally; forced to zero while empty so
            // the output is deterministic out of reset.
            assign read_data  = fifo_is_empty ? '0 : mem[rd_ptr];
            assign read_valid = ~fifo_is_empty;
        end else begin : g_normal
            logic [DATA_WIDTH-1:0] rd_q;
            logic                  rv_q;
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    rd_q <= '0;
                    rv_q <= 1'b0;
                end else if (sclr) begin
                    rv_q <= 1'b0;
                end else begin
                    rv_q <= pop;
                    if (pop) rd_q <= mem[rd_ptr];
                end
            end
            assign read_data  = rd_q;
            assign read_valid = rv_q;
        end
    endgenerate

endmodule

// File: tb/tb_up_sync_fifo_gen.sv
// Bench for up_sync_fifo_gen: drives a show-ahead and a normal-mode instance with
// identical stimulus and compares both against a queue-based model every cycle.
module tb_up_sync_fifo_gen;
    localparam int DW    = 32;
    localparam int AW    = 7;
    localparam int DEPTH = 1 << AW;
    localparam int AFL   = 120;
    localparam int AEL   = 8;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          sclr = 1'b0;
    logic          write_en = 1'b0;
    logic [DW-1:0] write_data = '0;
    logic          read_en = 1'b0;

    logic [DW-1:0] sa_rd, na_rd;
    logic          sa_rv, na_rv, sa_em, na_em, sa_fu, na_fu;
    logic          sa_ae, na_ae, sa_af, na_af, sa_ov, na_ov, sa_un, na_un;
    logic [AW:0]   sa_wu, na_wu;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    up_sync_fifo_gen #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .SHOWAHEAD(1'b1),
                       .ALMOST_FULL_LEVEL(AFL), .ALMOST_EMPTY_LEVEL(AEL)) u_sa (
        .clk(clk), .reset(reset), .sclr(sclr), .write_en(write_en), .write_data(write_data),
        .read_en(read_en), .read_data(sa_rd), .read_valid(sa_rv), .fifo_is_empty(sa_em),
        .fifo_is_full(sa_fu), .almost_empty(sa_ae), .almost_full(sa_af), .words_used(sa_wu),
        .overflow(sa_ov), .underflow(sa_un));

    up_sync_fifo_gen #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .SHOWAHEAD(1'b0),
                       .ALMOST_FULL_LEVEL(AFL), .ALMOST_EMPTY_LEVEL(AEL)) u_na (
        .clk(clk), .reset(reset), .sclr(sclr), .write_en(write_en), .write_data(write_data),
        .read_en(read_en), .read_data(na_rd), .read_valid(na_rv), .fifo_is_empty(na_em),
        .fifo_is_full(na_fu), .almost_empty(na_ae), .almost_full(na_af), .words_used(na_wu),
        .overflow(na_ov), .underflow(na_un));

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: a queue of stored words plus sticky bits and the
    // normal-mode output register.
    logic [DW-1:0] q[$];
    logic          m_ov = 1'b0, m_un = 1'b0, m_rv0 = 1'b0;
    logic [DW-1:0] m_rd0 = '0;
    logic          m_pop, m_push;
    int            m_cnt = 0;

    assign m_pop  = read_en && (m_cnt != 0);
    assign m_push = write_en && ((m_cnt < DEPTH) || m_pop);

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            q.delete();
            m_cnt <= 0;
            m_ov  <= 1'b0;
            m_un  <= 1'b0;
            m_rv0 <= 1'b0;
            m_rd0 <= '0;
        end else if (sclr) begin
            q.delete();
            m_cnt <= 0;
            m_ov  <= 1'b0;
            m_un  <= 1'b0;
            m_rv0 <= 1'b0;
        end else begin
            if (write_en && !m_push) m_ov <= 1'b1;
            if (read_en && !m_pop)   m_un <= 1'b1;
            m_rv0 <= m_pop;
            if (m_pop)  m_rd0 <= q.pop_front();
            if (m_push) q.push_back(write_data);
            m_cnt <= m_cnt + int'(m_push) - int'(m_pop);
        end
    end

    // Every-cycle comparison, away from the rising edge.
    always @(negedge clk) begin
        int n;
        logic [DW-1:0] head;
        n    = q.size();
        head = (n == 0) ? '0 : q[0];
        chk("sa_words_used", 64'(sa_wu), 64'(n));
        chk("na_words_used", 64'(na_wu), 64'(n));
        chk("sa_empty",      64'(sa_em), 64'(n == 0));
        chk("na_empty",      64'(na_em), 64'(n == 0));
        chk("sa_full",       64'(sa_fu), 64'(n == DEPTH));
        chk("na_full",       64'(na_fu), 64'(n == DEPTH));
        chk("sa_almost_empty", 64'(sa_ae), 64'(n <= AEL));
        chk("sa_almost_full",  64'(sa_af), 64'(n >= AFL));
        chk("na_almost_empty", 64'(na_ae), 64'(n <= AEL));
        chk("na_almost_full",  64'(na_af), 64'(n >= AFL));
        chk("sa_overflow",   64'(sa_ov), 64'(m_ov));
        chk("sa_underflow",  64'(sa_un), 64'(m_un));
        chk("na_overflow",   64'(na_ov), 64'(m_ov));
        chk("na_underflow",  64'(na_un), 64'(m_un));
        chk("sa_read_data",  64'(sa_rd), 64'(head));
        chk("sa_read_valid", 64'(sa_rv), 64'(n != 0));
        chk("na_read_valid", 64'(na_rv), 64'(m_rv0));
        chk("na_read_data",  64'(na_rd), 64'(m_rd0));
    end

    // Apply one cycle of inputs; returns 1 time unit after the sampling edge.
    task automatic cyc(input logic we, input logic re, input logic [DW-1:0] wd, input logic sc);
        write_en = we; read_en = re; write_data = wd; sclr = sc;
        @(posedge clk);
        #1;
        write_en = 1'b0; read_en = 1'b0; sclr = 1'b0;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_words_used", 64'(sa_wu), 64'd0);
        chk("rst_empty", 64'(sa_em), 64'd1);
        chk("rst_almost_empty", 64'(na_ae), 64'd1);
        chk("rst_almost_full", 64'(na_af), 64'd0);
        chk("rst_na_read_data", 64'(na_rd), 64'd0);
        reset = 1'b0;

        // Fill with 0..127, then one rejected push.
        for (int i = 0; i < DEPTH; i++) begin
            cyc(1'b1, 1'b0, DW'(i), 1'b0);
            chk("fill_words_used", 64'(sa_wu), 64'(i + 1));
            if (i == 118) chk("af_at_119", 64'(sa_af), 64'd0);
            if (i == 119) chk("af_at_120", 64'(sa_af), 64'd1);
        end
        chk("full_after_128", 64'(sa_fu), 64'd1);
        cyc(1'b1, 1'b0, 32'd999, 1'b0);
        chk("overflow_129th", 64'(sa_ov), 64'd1);
        chk("count_held_128", 64'(sa_wu), 64'd128);

        // Drain in order, then one rejected pop.
        for (int i = 0; i < DEPTH; i++) begin
            chk("drain_data", 64'(sa_rd), 64'(i));
            cyc(1'b0, 1'b1, '0, 1'b0);
            if (i == 118) chk("ae_at_9", 64'(sa_ae), 64'd0);
            if (i == 119) chk("ae_at_8", 64'(sa_ae), 64'd1);
        end
        chk("empty_after_drain", 64'(sa_em), 64'd1);
        cyc(1'b0, 1'b1, '0, 1'b0);
        chk("underflow_extra", 64'(sa_un), 64'd1);
        cyc(1'b1, 1'b0, 32'd77, 1'b0);
        chk("rdptr_kept", 64'(sa_rd), 64'd77);
        cyc(1'b0, 1'b1, '0, 1'b0);

        // Steady occupancy 5 with push+pop every cycle across pointer wraps.
        cyc(1'b0, 1'b0, '0, 1'b1);
        for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, $urandom, 1'b0);
        for (int i = 0; i < 300; i++) cyc(1'b1, 1'b1, $urandom, 1'b0);
        chk("steady_count", 64'(sa_wu), 64'd5);

        // Push+pop while full.
        cyc(1'b0, 1'b0, '0, 1'b1);
        for (int i = 0; i < DEPTH; i++) cyc(1'b1, 1'b0, DW'(1000 + i), 1'b0);
        cyc(1'b1, 1'b1, 32'hDEAD_BEEF, 1'b0);
        chk("full_pushpop_full", 64'(sa_fu), 64'd1);
        for (int i = 0; i < DEPTH - 1; i++) cyc(1'b0, 1'b1, '0, 1'b0);
        chk("full_pushpop_word", 64'(sa_rd), 64'hDEAD_BEEF);

        // Normal-mode read timing.
        cyc(1'b0, 1'b0, '0, 1'b1);
        cyc(1'b1, 1'b0, 32'hA5A5_A5A5, 1'b0);
        cyc(1'b0, 1'b1, '0, 1'b0);
        chk("na_valid_pulse", 64'(na_rv), 64'd1);
        chk("na_data", 64'(na_rd), 64'hA5A5_A5A5);
        cyc(1'b0, 1'b0, '0, 1'b0);
        chk("na_valid_drop", 64'(na_rv), 64'd0);
        chk("na_data_held", 64'(na_rd), 64'hA5A5_A5A5);

        // sclr with a concurrent write, then asynchronous reset mid-cycle.
        cyc(1'b0, 1'b1, '0, 1'b0);
        for (int i = 0; i < 10; i++) cyc(1'b1, 1'b0, $urandom, 1'b0);
        cyc(1'b1, 1'b0, 32'h55, 1'b1);
        chk("sclr_words_used", 64'(sa_wu), 64'd0);
        chk("sclr_empty", 64'(na_em), 64'd1);
        chk("sclr_overflow", 64'(sa_ov), 64'd0);
        chk("sclr_underflow", 64'(sa_un), 64'd0);
        for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, $urandom, 1'b0);
        cyc(1'b0, 1'b1, '0, 1'b0);
        #2;
        reset = 1'b1;
        #1;
        chk("arst_words_used", 64'(sa_wu), 64'd0);
        chk("arst_empty", 64'(sa_em), 64'd1);
        chk("arst_sa_data", 64'(sa_rd), 64'd0);
        chk("arst_na_valid", 64'(na_rv), 64'd0);
        chk("arst_na_data", 64'(na_rd), 64'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Random traffic with occasional clears.
        for (int i = 0; i < 3000; i++) begin
            cyc(1'($urandom_range(0, 99) < 55), 1'($urandom_range(0, 99) < 50),
                $urandom, 1'($urandom_range(0, 63) == 0));
        end

        @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
